// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that drives the select lines of a shared 4:1 mux; grants are held until released.
// Define MUX4_ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles when another requester is waiting.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       sel_s1,
    output logic       sel_s2,
    output logic       busy,
    output logic [1:0] owner
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic [2:0]       pick_all;
    logic [2:0]       pick_oth;
    logic             take;
    logic [1:0]       win;

    // Returns {found, index}: first set bit scanning base+1, base+2, base+3 and, if allowed, base itself.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base,
                                           input logic incl_base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!res[2] && r[idx] && (i != 4 || incl_base)) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign pick_all = rr_pick(req, ptr_q, 1'b1);
    assign pick_oth = rr_pick(req, owner_q, 1'b0);

    // Next-state logic: decide whether a new winner takes the channel this edge.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        take    = 1'b0;
        win     = 2'd0;

        case (state_q)
            IDLE: begin
                take = pick_all[2];
                win  = pick_all[1:0];
                if (!take) begin
                    gnt_d  = 4'b0000;
                    busy_d = 1'b0;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    // Released owner is excluded; it can only return through IDLE.
                    take = pick_oth[2];
                    win  = pick_oth[1:0];
                    if (!take) begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                        hold_d  = '0;
                    end
                end else begin
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + CNT_W'(1);
                    end
`ifdef MUX4_ARB_TIMEOUT_EN
                    if (hold_q == HOLD_MAX && pick_oth[2]) begin
                        take = 1'b1;
                        win  = pick_oth[1:0];
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << win;
            owner_d = win;
            ptr_d   = win;
            busy_d  = 1'b1;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            owner_q <= 2'd0;
            ptr_q   <= 2'd3;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt    = gnt_q;
    assign owner  = owner_q;
    assign sel_s1 = owner_q[0];
    assign sel_s2 = owner_q[1];
    assign busy   = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: vector table plus a hold-timeout sequence.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       sel_s1;
    logic       sel_s2;
    logic       busy;
    logic [1:0] owner;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] own;
        logic       busy;
    } vec_t;

    vec_t vq[$];

    mux4_rr_arbiter #(
        .MAX_HOLD(4),
        .CNT_W   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt),
        .sel_s1(sel_s1),
        .sel_s2(sel_s2),
        .busy  (busy),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                       input logic [1:0] o, input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.gnt = g; v.own = o; v.busy = b;
        vq.push_back(v);
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] o,
                              input logic b);
        check({tag, " gnt"}, 32'(gnt), 32'(g));
        check({tag, " owner"}, 32'(owner), 32'(o));
        check({tag, " sel"}, 32'({sel_s2, sel_s1}), 32'(o));
        check({tag, " busy"}, 32'(busy), 32'(b));
        check({tag, " onehot"}, 32'($onehot0(gnt)), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;

        // reset held two cycles with all requests up
        add(1, 4'b1111, 4'b0000, 2'd0, 0);
        add(1, 4'b1111, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 1);
        // round robin, owner drops for one cycle each time
        add(0, 4'b1110, 4'b0010, 2'd1, 1);
        add(0, 4'b1101, 4'b0100, 2'd2, 1);
        add(0, 4'b1011, 4'b1000, 2'd3, 1);
        add(0, 4'b0111, 4'b0001, 2'd0, 1);
        add(0, 4'b0000, 4'b0000, 2'd0, 0);
        // single requester held five cycles, then idle keeps select
        add(0, 4'b0100, 4'b0100, 2'd2, 1);
        add(0, 4'b0100, 4'b0100, 2'd2, 1);
        add(0, 4'b0100, 4'b0100, 2'd2, 1);
        add(0, 4'b0100, 4'b0100, 2'd2, 1);
        add(0, 4'b0100, 4'b0100, 2'd2, 1);
        add(0, 4'b0000, 4'b0000, 2'd2, 0);
        add(0, 4'b0000, 4'b0000, 2'd2, 0);
        // priority after release: owner 2, req 0100 -> 1001 picks 3
        add(0, 4'b0100, 4'b0100, 2'd2, 1);
        add(0, 4'b1001, 4'b1000, 2'd3, 1);
        add(0, 4'b1001, 4'b1000, 2'd3, 1);
        // reset mid-grant, then pointer back to 3
        add(0, 4'b0010, 4'b0010, 2'd1, 1);
        add(1, 4'b1111, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 1);
        // owner returns only through idle
        add(0, 4'b0000, 4'b0000, 2'd0, 0);
        add(0, 4'b0001, 4'b0001, 2'd0, 1);
        add(0, 4'b1111, 4'b0001, 2'd0, 1);
        add(0, 4'b1110, 4'b0010, 2'd1, 1);
        add(0, 4'b0000, 4'b0000, 2'd1, 0);

        @(posedge clk);
        #1;
        foreach (vq[i]) begin
            reset = vq[i].rst;
            req   = vq[i].req;
            @(posedge clk);
            #1;
            check_outs($sformatf("v%0d", i), vq[i].gnt, vq[i].own, vq[i].busy);
        end

        // hold timeout: two requesters held constant
        reset = 1'b1;
        req   = 4'b0011;
        @(posedge clk);
        #1;
        check_outs("to_rst", 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] eg;
            logic [1:0] eo;
            @(posedge clk);
            #1;
`ifdef MUX4_ARB_TIMEOUT_EN
            eo = ((k / 4) % 2 == 0) ? 2'd0 : 2'd1;
`else
            eo = 2'd0;
`endif
            eg = 4'b0001 << eo;
            check_outs($sformatf("to%0d", k), eg, eo, 1'b1);
        end

        req = 4'b0000;
        @(posedge clk);
        #1;
        check("to_end busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
